// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM: steps each instruction through FETCH, DECODE, EXECUTE,
// MEMORY and WRITE, owning the memory handshakes, the memory timeout and the trap.
module stage_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic [31:0]      ir_i,
  input  logic             imem_ack_i,
  input  logic             dmem_ack_i,
  output logic [2:0]       stage_o,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             ir_load_o,
  output logic             wd_q_readin_o,
  output logic             pc_load_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o
);

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEMORY  = 3'd4,
    S_WRITE   = 3'd5,
    S_TRAP    = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             is_load_q, is_load_d;
  logic             is_store_q, is_store_d;
  logic             no_wb_q, no_wb_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             imem_req_q, imem_req_d;
  logic             dmem_req_q, dmem_req_d;
  logic             dmem_we_q, dmem_we_d;
  logic             wd_q, wd_d;
  logic             pc_load_q, pc_load_d;
  logic             retire_q, retire_d;
  logic             trap_q, trap_d;

  logic             op_legal, op_load, op_store, op_nowb;
  logic             unused_ir;

  assign unused_ir = ^ir_i[31:7];

  always_comb begin
    op_legal = 1'b1;
    op_load  = 1'b0;
    op_store = 1'b0;
    op_nowb  = 1'b0;
    case (ir_i[6:0])
      7'b0110011, 7'b0010011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111: op_legal = 1'b1;
      7'b0000011: op_load = 1'b1;
      7'b0100011: begin
        op_store = 1'b1;
        op_nowb  = 1'b1;
      end
      7'b1100011: op_nowb = 1'b1;
      default:    op_legal = 1'b0;
    endcase
  end

  // Outputs are registered from the next state so every strobe lines up with stage_o.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    is_load_d    = is_load_q;
    is_store_d   = is_store_q;
    no_wb_d      = no_wb_q;
    cause_d      = cause_q;
    retire_cnt_d = retire_cnt_q;
    case (state_q)
      S_IDLE: if (run_i) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack_i) begin
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DECODE: begin
        is_load_d  = op_load;
        is_store_d = op_store;
        no_wb_d    = op_nowb;
        if (op_legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end
      end
      S_EXECUTE: state_d = (is_load_q || is_store_q) ? S_MEMORY : S_WRITE;
      S_MEMORY: begin
        if (dmem_ack_i) begin
          state_d = S_WRITE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WRITE: state_d = run_i ? S_FETCH : S_IDLE;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_FETCH || state_d == S_MEMORY) && state_d != state_q) tmo_d = '0;
    if (state_d == S_WRITE) retire_cnt_d = retire_cnt_q + CNT_W'(1);

    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEMORY);
    dmem_we_d  = (state_d == S_MEMORY) && is_store_d;
    wd_d       = (state_d == S_WRITE) && !no_wb_d;
    pc_load_d  = (state_d == S_WRITE);
    retire_d   = (state_d == S_WRITE);
    trap_d     = (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      no_wb_q      <= 1'b0;
      cause_q      <= 2'd0;
      retire_cnt_q <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      wd_q         <= 1'b0;
      pc_load_q    <= 1'b0;
      retire_q     <= 1'b0;
      trap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      is_load_q    <= is_load_d;
      is_store_q   <= is_store_d;
      no_wb_q      <= no_wb_d;
      cause_q      <= cause_d;
      retire_cnt_q <= retire_cnt_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      wd_q         <= wd_d;
      pc_load_q    <= pc_load_d;
      retire_q     <= retire_d;
      trap_q       <= trap_d;
    end
  end

  assign stage_o       = state_q;
  assign imem_req_o    = imem_req_q;
  assign dmem_req_o    = dmem_req_q;
  assign dmem_we_o     = dmem_we_q;
  assign ir_load_o     = (state_q == S_FETCH) && imem_ack_i && !reset;
  assign wd_q_readin_o = wd_q;
  assign pc_load_o     = pc_load_q;
  assign retire_o      = retire_q;
  assign retire_cnt_o  = retire_cnt_q;
  assign trap_o        = trap_q;
  assign trap_cause_o  = cause_q;

endmodule
